seq_pattern_tx: RTL and testbench

Serial pattern transmitter that drives a single-bit stream into a serial sequence detector. It shifts out a PAT_W-bit pattern MSB-first, one bit per clock, repeating it a programmable number of times. Consecutive repetitions are sent either back-to-back or separated by a one-cycle idle gap. The block serves as the stimulus source on the transmit side of the serial detection link, and also as the on-chip self-test generator for that link.

---
 rtl/seq_pattern_tx.sv | 157 +++++++++++++++
 tb/tb_seq_pattern_tx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a PAT_W-bit pattern out MSB-first, repeated rep_cnt times.
// Latency: first bit on d_out one cycle after the start edge; done pulses the cycle after the last bit.
// Backpressure: none, the stream is free-running once started; abort is the only way to stop it early.
//
// Ports:
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   pat_load, pat_in      load a new pattern (IDLE only)
//   start, rep_cnt        begin a run of rep_cnt repetitions (0 means 1), sampled in IDLE
//   gap_en                one idle cycle between repetitions, sampled at the end of each repetition
//   abort                 synchronous return to IDLE without a done pulse
//   d_out, valid          registered serial data and its qualifier
//   busy, done            run in progress (SHIFT/GAP), one-cycle completion pulse
module seq_pattern_tx #(
  parameter int                PAT_W   = 6,
  parameter logic [PAT_W-1:0]  PAT_RST = 6'b110101,
  parameter int                CNT_W   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             start,
  input  logic [CNT_W-1:0] rep_cnt,
  input  logic             gap_en,
  input  logic             abort,
  output logic             d_out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int                IDX_W   = $clog2(PAT_W);
  localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   pat_reg_q, pat_reg_d;
  logic [PAT_W-1:0]   shadow_q, shadow_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]   rep_left_q, rep_left_d;
  logic               d_out_q, d_out_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Outputs are computed from the current state and registered, so they
  // describe what happens in the cycle after the state was entered.
  always_comb begin
    state_d    = state_q;
    pat_reg_d  = pat_reg_q;
    shadow_d   = shadow_q;
    bit_idx_d  = bit_idx_q;
    rep_left_d = rep_left_q;
    d_out_d    = 1'b0;
    valid_d    = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pat_load) begin
          pat_reg_d = pat_in;
        end
        if (start && !abort) begin
          // A load in the same cycle as start transmits the new pattern.
          shadow_d   = pat_load ? pat_in : pat_reg_q;
          rep_left_d = (rep_cnt == '0) ? CNT_W'(1) : rep_cnt;
          bit_idx_d  = IDX_MAX;
          state_d    = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        d_out_d = shadow_q[bit_idx_q];
        valid_d = 1'b1;
        busy_d  = 1'b1;
        if (bit_idx_q == '0) begin
          // Guarded decrement: rep_left never wraps below zero.
          if (rep_left_q != '0) begin
            rep_left_d = rep_left_q - CNT_W'(1);
          end
          if (rep_left_q > CNT_W'(1)) begin
            bit_idx_d = IDX_MAX;
            if (gap_en) begin
              state_d = ST_GAP;
            end
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          bit_idx_d = bit_idx_q - IDX_W'(1);
        end
      end

      ST_GAP: begin
        busy_d    = 1'b1;
        bit_idx_d = IDX_MAX;
        state_d   = ST_SHIFT;
      end

      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides whatever the active state would have produced,
    // including a pending done pulse; pat_reg is left untouched.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      d_out_d = 1'b0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pat_reg_q  <= PAT_RST;
      shadow_q   <= '0;
      bit_idx_q  <= '0;
      rep_left_q <= '0;
      d_out_q    <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pat_reg_q  <= pat_reg_d;
      shadow_q   <= shadow_d;
      bit_idx_q  <= bit_idx_d;
      rep_left_q <= rep_left_d;
      d_out_q    <= d_out_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign d_out = d_out_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: directed and randomized runs against a cycle trace model.
// Latency: expects first bit one cycle after start, done one cycle after the last bit.
// Backpressure: not applicable; abort and asynchronous reset are exercised mid-run.
module tb_seq_pattern_tx;

  localparam int          PAT_W   = 6;
  localparam int          CNT_W   = 4;
  localparam logic [5:0]  PAT_RST = 6'b110101;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             start;
  logic [CNT_W-1:0] rep_cnt;
  logic             gap_en;
  logic             abort;
  logic             d_out;
  logic             valid;
  logic             busy;
  logic             done;

  seq_pattern_tx #(
    .PAT_W   (PAT_W),
    .PAT_RST (PAT_RST),
    .CNT_W   (CNT_W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .pat_load (pat_load),
    .pat_in   (pat_in),
    .start    (start),
    .rep_cnt  (rep_cnt),
    .gap_en   (gap_en),
    .abort    (abort),
    .d_out    (d_out),
    .valid    (valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         passes = 0;
  int         fails  = 0;
  int         run_id = 0;
  logic [5:0] model_pat;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observed vector is {busy, valid, d_out, done}.
  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {busy, valid, d_out, done};
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed(busy,valid,d_out,done)=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Expected output trace for a run, one entry per cycle after the first
  // bit cycle: every repetition's bits MSB-first, a gap entry between
  // repetitions when enabled, the done pulse, then one idle cycle.
  task automatic build_trace(input logic [5:0] p, input int rep, input bit gap,
                             output logic [3:0] q[$]);
    int reps;
    q = {};
    reps = (rep == 0) ? 1 : rep;
    for (int r = 0; r < reps; r++) begin
      for (int i = PAT_W - 1; i >= 0; i--) q.push_back({1'b1, 1'b1, p[i], 1'b0});
      if (gap && (r < reps - 1)) q.push_back(4'b1000);
    end
    q.push_back(4'b0001);
    q.push_back(4'b0000);
  endtask

  // One full run. ld loads np together with start. disturb pulses start and
  // pat_load with junk in the middle of the run; the model ignores it.
  task automatic run(input int rep, input bit gap, input bit ld,
                     input logic [5:0] np, input bit disturb);
    logic [3:0] q[$];
    if (ld) model_pat = np;
    build_trace(model_pat, rep, gap, q);
    run_id++;
    pat_in   = np;
    pat_load = ld;
    rep_cnt  = CNT_W'(rep);
    gap_en   = gap;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    pat_load = 1'b0;
    chk($sformatf("run%0d_latency", run_id), 4'b0000);
    for (int i = 0; i < q.size(); i++) begin
      if (disturb && (i == 2)) begin
        start    = 1'b1;
        pat_load = 1'b1;
        pat_in   = ~model_pat;
        rep_cnt  = CNT_W'($urandom_range(1, 15));
      end
      tick();
      start    = 1'b0;
      pat_load = 1'b0;
      chk($sformatf("run%0d_c%0d", run_id, i), q[i]);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    pat_load = 1'b0;
    pat_in   = '0;
    start    = 1'b0;
    rep_cnt  = '0;
    gap_en   = 1'b0;
    abort    = 1'b0;
    model_pat = PAT_RST;

    #12;
    chk("reset_state", 4'b0000);
    reset_n = 1'b1;
    tick();
    chk("post_reset_idle", 4'b0000);

    // Reset pattern, single repetition, no gap.
    run(1, 1'b0, 1'b0, 6'b000000, 1'b0);

    // Load alone in IDLE, then three repetitions without and with gaps.
    pat_in   = 6'b101100;
    pat_load = 1'b1;
    tick();
    pat_load = 1'b0;
    model_pat = 6'b101100;
    chk("load_idle", 4'b0000);
    run(3, 1'b0, 1'b0, 6'b000000, 1'b0);
    run(3, 1'b1, 1'b0, 6'b000000, 1'b0);

    // rep_cnt=0 sends one pattern; mid-run start/load must be ignored,
    // and the following run must still use the unchanged pattern.
    run(0, 1'b0, 1'b0, 6'b000000, 1'b1);
    run(2, 1'b1, 1'b0, 6'b000000, 1'b0);

    // Simultaneous load and start transmits the new pattern.
    run(2, 1'b0, 1'b1, 6'b011010, 1'b0);

    // Abort on the third bit: outputs drop next cycle, no done pulse.
    rep_cnt = 4'd2;
    gap_en  = 1'b0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    chk("abort_lat", 4'b0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("abort_bit%0d", i), {1'b1, 1'b1, model_pat[PAT_W-1-i], 1'b0});
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_drop", 4'b0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("abort_nodone%0d", i), 4'b0000);
    end
    run(1, 1'b0, 1'b0, 6'b000000, 1'b0);

    // Abort in IDLE wins over start.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("idle_abort%0d", i), 4'b0000);
    end

    // Randomized runs.
    for (int n = 0; n < 10; n++) begin
      run($urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          6'($urandom), 1'($urandom_range(0, 1)));
    end

    // Make pat_reg differ from the reset value, then reset mid-run.
    run(1, 1'b0, 1'b1, 6'b001011, 1'b0);
    rep_cnt = 4'd3;
    gap_en  = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre_reset_bit", {1'b1, 1'b1, model_pat[PAT_W-2], 1'b0});
    #1 reset_n = 1'b0;
    #1 chk("async_reset", 4'b0000);
    #1 reset_n = 1'b1;
    model_pat = PAT_RST;
    tick();
    chk("after_reset_idle", 4'b0000);
    run(1, 1'b0, 1'b0, 6'b000000, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
